multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the LEGv8 datapath.
- Sequences a single shared ALU, memory port, register file and PC through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = address add, 01 = branch compare, 10 = R-format function decode.
- Takes the 11-bit opcode field from the instruction register and a memory ready handshake; retires one instruction per 3–5+ cycles.

Parameters:
- MEM_TIMEOUT, 16: max cycles to wait for mem_ready in any memory state before trapping; 0 disables the timeout.
- CNT_W, 5: width of the internal wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  11  instruction[31:21] from the instruction register; valid from DECODE onward.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if the ALU zero flag is set.
- pc_source  output  2  00 = ALU result, 01 = ALUOut register, 10 = unconditional branch target.
- ir_write  output  1  latch fetched instruction.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- i_or_d  output  1  0 = PC address, 1 = ALUOut address.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended D offset, 11 = branch offset << 2.
- alu_op  output  2  ALUOp to the ALU control decoder.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- trap  output  1  sticky error flag.
- trap_cause  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, active-high):
  - state = FETCH(0), wait counter = 0, trap = 0, trap_cause = 00.
  - While reset is asserted, all strobes are 0 and the mux selects are 0.
  - Reset asserted mid-operation aborts the current instruction immediately; no partial writeback occurs.
- Outputs are decoded combinationally from state. ir_write, pc_write and instr_done are additionally gated by mem_ready where stated. Any output not listed for a state is 0.
- Opcode decode, evaluated in DECODE:
  - R-format: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR.
  - LDUR: 11111000010. STUR: 11111000000.
  - CBZ: opcode[10:3] = 10110100. B: opcode[10:5] = 000101.
  - Anything else is illegal.
- States, outputs and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Next state: R → R_EXEC, LDUR/STUR → MEM_ADDR, CBZ → CBZ_EXEC, B → B_EXEC, illegal → TRAP with cause 01.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD if LDUR, else MEM_WR.
  - MEM_RD(3): mem_read=1, i_or_d=1. Hold until mem_ready, then go to LD_WB.
  - LD_WB(4): reg_write=1, mem_to_reg=1, instr_done=1. Go to FETCH.
  - MEM_WR(5): mem_write=1, i_or_d=1. Hold until mem_ready; when mem_ready, instr_done=1 and go to FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
  - R_WB(7): reg_write=1, mem_to_reg=0, instr_done=1. Go to FETCH.
  - CBZ_EXEC(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
  - B_EXEC(9): pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
  - TRAP(10): trap=1, all strobes 0. Absorbing; only reset exits.
- Wait counter (memory states FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to each memory state; increments each cycle mem_ready=0 while in that state.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: next state TRAP, cause 10.
  - mem_ready=1 in the same cycle the counter reaches its limit counts as success; ready wins over timeout.
- Unused state encodings 11–15 go to TRAP with cause 01.
- Latency with mem_ready tied high: R = 4 cycles, LDUR = 5, STUR = 4, CBZ = 3, B = 3.

Test Plan:
- Reset pulse mid MEM_RD, with mem_ready held high afterward → state=0 immediately (asynchronous), reg_write never asserted, FETCH resumes on the next edge.
- ADD opcode 10001011000, mem_ready=1 → states 0,1,6,7,0; alu_op=10 in state 6; reg_write=1 only in state 7; instr_done pulses once.
- LDUR 11111000010, mem_ready low 3 cycles in MEM_RD → states 0,1,2,3,3,3,3,4,0; mem_read held high throughout state 3; mem_to_reg=1 in state 4.
- CBZ opcode 10110100xxx → alu_op=01, pc_write_cond=1, pc_source=01 for exactly one cycle; B opcode 000101xxxxx → pc_write=1, pc_source=10.
- Opcode 00000000000 → TRAP after DECODE, trap_cause=01, stays there for 100 cycles with all strobes 0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 → TRAP on the 17th cycle with cause 10; repeat with mem_ready=1 exactly on the 16th wait cycle → DECODE, no trap.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the LEGv8 multi-cycle main controller and its datapath.
// The controller (master) consumes opcode/mem_ready and drives every datapath control.
interface multicycle_control_if;
   logic [10:0] opcode;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  pc_source;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        i_or_d;
   logic        reg_write;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        instr_done;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [3:0]  state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write,
             i_or_d, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             instr_done, trap, trap_cause, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write,
             i_or_d, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             instr_done, trap, trap_cause, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with a memory-wait timeout and sticky trap.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic reset,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      LD_WB    = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      CBZ_EXEC = 4'd8,
      B_EXEC   = 4'd9,
      TRAP     = 4'd10
   } state_e;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;

   logic [CNT_W-1:0] cnt_inc;
   logic             timeout;
   logic             is_r, is_mem, is_cbz, is_b;

   assign cnt_inc = cnt_q + 1'b1;
   assign timeout = (MEM_TIMEOUT != 0) && (cnt_inc == CNT_W'(MEM_TIMEOUT));

   assign is_r   = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                   (bus.opcode == OP_AND) || (bus.opcode == OP_ORR);
   assign is_mem = (bus.opcode == OP_LDUR) || (bus.opcode == OP_STUR);
   assign is_cbz = (bus.opcode[10:3] == 8'b10110100);
   assign is_b   = (bus.opcode[10:5] == 6'b000101);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // The wait counter defaults to zero so it is cleared on entry to every memory state;
   // mem_ready is tested before the timeout so a ready on the last wait cycle still succeeds.
   always_comb begin
      state_d           = state_q;
      cnt_d             = '0;
      cause_d           = cause_q;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.pc_source     = 2'b00;
      bus.ir_write      = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.reg_write     = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.instr_done    = 1'b0;
      bus.trap          = 1'b0;

      case (state_q)
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_d      = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DECODE: begin
            bus.alu_src_b = 2'b11;
            if (is_r)        state_d = R_EXEC;
            else if (is_mem) state_d = MEM_ADDR;
            else if (is_cbz) state_d = CBZ_EXEC;
            else if (is_b)   state_d = B_EXEC;
            else begin
               state_d = TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = (bus.opcode == OP_LDUR) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
            if (bus.mem_ready) begin
               state_d = LD_WB;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         LD_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            bus.instr_done = 1'b1;
            state_d        = FETCH;
         end
         MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
            if (bus.mem_ready) begin
               bus.instr_done = 1'b1;
               state_d        = FETCH;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         R_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
            state_d       = R_WB;
         end
         R_WB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
            state_d        = FETCH;
         end
         CBZ_EXEC: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
            bus.instr_done    = 1'b1;
            state_d           = FETCH;
         end
         B_EXEC: begin
            bus.pc_write   = 1'b1;
            bus.pc_source  = 2'b10;
            bus.instr_done = 1'b1;
            state_d        = FETCH;
         end
         TRAP: begin
            bus.trap = 1'b1;
         end
         default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase

      // Asynchronous reset must silence the datapath at once, not just on the next edge.
      if (reset) begin
         bus.pc_write      = 1'b0;
         bus.pc_write_cond = 1'b0;
         bus.pc_source     = 2'b00;
         bus.ir_write      = 1'b0;
         bus.mem_read      = 1'b0;
         bus.mem_write     = 1'b0;
         bus.i_or_d        = 1'b0;
         bus.reg_write     = 1'b0;
         bus.mem_to_reg    = 1'b0;
         bus.alu_src_a     = 1'b0;
         bus.alu_src_b     = 2'b00;
         bus.alu_op        = 2'b00;
         bus.instr_done    = 1'b0;
         bus.trap          = 1'b0;
      end
   end

   assign bus.state      = state_q;
   assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for the multi-cycle LEGv8 control FSM, with
// hand-written sequences for memory stalls, reset abort, illegal opcode and timeout.
module tb_multicycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       trap;
   } ctrl_t;

   typedef struct {
      string       name;
      logic [10:0] opcode;
      int          n;
      logic [4:0][3:0] seq;
   } vec_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   function automatic ctrl_t actual();
      ctrl_t c;
      c.pc_write      = bus.pc_write;
      c.pc_write_cond = bus.pc_write_cond;
      c.pc_source     = bus.pc_source;
      c.ir_write      = bus.ir_write;
      c.mem_read      = bus.mem_read;
      c.mem_write     = bus.mem_write;
      c.i_or_d        = bus.i_or_d;
      c.reg_write     = bus.reg_write;
      c.mem_to_reg    = bus.mem_to_reg;
      c.alu_src_a     = bus.alu_src_a;
      c.alu_src_b     = bus.alu_src_b;
      c.alu_op        = bus.alu_op;
      c.instr_done    = bus.instr_done;
      c.trap          = bus.trap;
      return c;
   endfunction

   // Expected control word for each state, written straight from the state table.
   function automatic ctrl_t expCtrl(input logic [3:0] st, input logic rdy);
      ctrl_t c;
      c = '0;
      case (st)
         4'd0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
         4'd1: c.alu_src_b = 2'b11;
         4'd2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         4'd3: begin c.mem_read = 1; c.i_or_d = 1; end
         4'd4: begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
         4'd5: begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = rdy; end
         4'd6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
         4'd7: begin c.reg_write = 1; c.instr_done = 1; end
         4'd8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; c.instr_done = 1; end
         4'd9: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
         4'd10: c.trap = 1;
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [10:0] opc, input logic rdy);
      bus.opcode    = opc;
      bus.mem_ready = rdy;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string name, input logic [3:0] st, input logic rdy);
      checkOutput({name, " state"}, 32'(bus.state), 32'(st));
      checkOutput({name, " ctrl"}, 32'(actual()), 32'(expCtrl(st, rdy)));
   endtask

   // Holds reset across one rising edge so the wait counter is cleanly zero afterwards.
   task automatic resetPulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   vec_t vecs[8];

   initial begin
      int done_cnt;

      vecs[0] = '{"ADD",  11'b10001011000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
      vecs[1] = '{"SUB",  11'b11001011000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
      vecs[2] = '{"AND",  11'b10001010000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
      vecs[3] = '{"ORR",  11'b10101010000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
      vecs[4] = '{"LDUR", 11'b11111000010, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
      vecs[5] = '{"STUR", 11'b11111000000, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
      vecs[6] = '{"CBZ",  11'b10110100101, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
      vecs[7] = '{"B",    11'b00010111111, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};

      reset = 1'b1;
      applyStimulus(11'd0, 1'b1);
      repeat (2) step();
      checkOutput("reset state", 32'(bus.state), 32'd0);
      checkOutput("reset ctrl", 32'(actual()), 32'd0);
      checkOutput("reset cause", 32'(bus.trap_cause), 32'd0);
      reset = 1'b0;
      #1;

      // Table-driven: every instruction class with memory always ready.
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].opcode, 1'b1);
         done_cnt = 0;
         for (int i = 0; i < vecs[v].n; i++) begin
            checkState($sformatf("%s c%0d", vecs[v].name, i), vecs[v].seq[i], 1'b1);
            done_cnt += int'(bus.instr_done);
            step();
         end
         checkOutput({vecs[v].name, " retire"}, 32'(bus.state), 32'd0);
         checkOutput({vecs[v].name, " done count"}, 32'(done_cnt), 32'd1);
      end

      $display("[TB] LDUR with three stall cycles in MEM_RD");
      applyStimulus(OP_LDUR, 1'b1);
      checkState("ldst fetch", 4'd0, 1'b1);
      step();
      checkState("ldst decode", 4'd1, 1'b1);
      step();
      applyStimulus(OP_LDUR, 1'b0);
      checkState("ldst addr", 4'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checkState($sformatf("ldst wait%0d", i), 4'd3, 1'b0);
      end
      step();
      applyStimulus(OP_LDUR, 1'b1);
      checkState("ldst rd ready", 4'd3, 1'b1);
      step();
      checkState("ldst wb", 4'd4, 1'b1);
      step();
      checkState("ldst back", 4'd0, 1'b1);

      $display("[TB] Reset abort in MEM_RD");
      step();
      step();
      applyStimulus(OP_LDUR, 1'b0);
      step();
      checkState("abort in rd", 4'd3, 1'b0);
      reset = 1'b1;
      applyStimulus(OP_LDUR, 1'b1);
      checkOutput("abort state", 32'(bus.state), 32'd0);
      checkOutput("abort ctrl", 32'(actual()), 32'd0);
      reset = 1'b0;
      #1;
      checkState("abort fetch", 4'd0, 1'b1);
      step();
      checkState("abort resume", 4'd1, 1'b1);
      checkOutput("abort cause", 32'(bus.trap_cause), 32'd0);

      $display("[TB] Illegal opcode");
      applyStimulus(11'd0, 1'b0);
      resetPulse();
      applyStimulus(11'd0, 1'b1);
      step();
      checkState("illegal decode", 4'd1, 1'b1);
      step();
      checkOutput("illegal cause", 32'(bus.trap_cause), 32'd1);
      for (int i = 0; i < 100; i++) begin
         checkState($sformatf("trap hold%0d", i), 4'd10, 1'b1);
         step();
      end
      applyStimulus(11'd0, 1'b0);
      resetPulse();
      checkOutput("trap cleared", 32'(bus.trap_cause), 32'd0);

      $display("[TB] FETCH timeout");
      for (int i = 0; i < 16; i++) begin
         checkState($sformatf("to wait%0d", i), 4'd0, 1'b0);
         step();
      end
      checkOutput("timeout state", 32'(bus.state), 32'd10);
      checkOutput("timeout cause", 32'(bus.trap_cause), 32'd2);
      checkOutput("timeout trap", 32'(bus.trap), 32'd1);

      $display("[TB] Ready on the last wait cycle");
      applyStimulus(OP_ADD, 1'b0);
      resetPulse();
      for (int i = 0; i < 15; i++) begin
         step();
      end
      applyStimulus(OP_ADD, 1'b1);
      checkState("late ready fetch", 4'd0, 1'b1);
      step();
      checkState("late ready decode", 4'd1, 1'b1);
      checkOutput("late ready cause", 32'(bus.trap_cause), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
